// File: rtl/sa_share.sv
// Shared definitions for the systolic-array feeder: FSM encoding, default
// geometry and the bench clock period.
package sa_share;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_W = 3'd1,
    ACT    = 3'd2,
    FLUSH  = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam int DEF_ROWS   = 4;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_CNT_W  = 16;

  localparam int TB_CLK_PERIOD = 10;

endpackage

// File: rtl/sa_skew_lane.sv
// Fixed-latency delay line for one activation lane; DEPTH=0 degenerates to
// a plain wire so lane 0 only sees the feeder's common output register.
module sa_skew_lane
  import sa_share::*;
#(
  parameter int DEPTH  = 1,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] d,
  input  logic              dv,
  output logic [DATA_W-1:0] q,
  output logic              qv
);

  if (DEPTH == 0) begin : g_wire
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ reset_n;
    assign q  = d;
    assign qv = dv;
  end else begin : g_pipe
    logic [DEPTH-1:0][DATA_W-1:0] pipe_d;
    logic [DEPTH-1:0]             pipe_v;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        pipe_d <= '0;
        pipe_v <= '0;
      end else begin
        pipe_d[0] <= d;
        pipe_v[0] <= dv;
        for (int i = 1; i < DEPTH; i++) begin
          pipe_d[i] <= pipe_d[i-1];
          pipe_v[i] <= pipe_v[i-1];
        end
      end
    end

    assign q  = pipe_d[DEPTH-1];
    assign qv = pipe_v[DEPTH-1];
  end

endmodule

// File: rtl/sa_feeder.sv
// Load-then-stream feeder for a 1-D systolic PE chain: shifts ROWS weights in,
// then streams n_vec activation vectors with a diagonal lane skew.
module sa_feeder
  import sa_share::*;
#(
  parameter int ROWS   = DEF_ROWS,
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [CNT_W-1:0]       n_vec,
  output logic                   busy,
  output logic                   done,
  input  logic                   w_valid,
  output logic                   w_ready,
  input  logic [DATA_W-1:0]      w_data,
  input  logic                   a_valid,
  output logic                   a_ready,
  input  logic [ROWS*DATA_W-1:0] a_data,
  output logic [DATA_W-1:0]      win,
  output logic                   wen,
  output logic [ROWS*DATA_W-1:0] ain,
  output logic [ROWS-1:0]        ain_valid
);

  localparam int              WC_W     = $clog2(ROWS) + 1;
  localparam logic [WC_W-1:0] LAST_IDX = WC_W'(ROWS - 1);

  state_t                   state, next_state;
  logic [WC_W-1:0]          w_cnt;
  logic [CNT_W-1:0]         v_cnt;
  logic [CNT_W-1:0]         n_vec_q;
  logic                     w_hs, a_hs;
  logic [ROWS*DATA_W-1:0]   lane_q;
  logic [ROWS-1:0]          lane_qv;

  assign w_hs = w_valid & w_ready;
  assign a_hs = a_valid & a_ready;

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (start) next_state = LOAD_W;
      LOAD_W:  if (w_hs && w_cnt == LAST_IDX)
                 next_state = (n_vec_q != '0) ? ACT : DONE;
      ACT:     if (a_hs && v_cnt == n_vec_q - CNT_W'(1)) next_state = FLUSH;
      FLUSH:   if (w_cnt == LAST_IDX) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Flag outputs are decoded from next_state so they line up with the state register.
  // w_cnt doubles as the FLUSH cycle counter; both counters restart on every transition.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      w_cnt   <= '0;
      v_cnt   <= '0;
      n_vec_q <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      w_ready <= 1'b0;
      a_ready <= 1'b0;
      win     <= '0;
      wen     <= 1'b0;
    end else begin
      state   <= next_state;
      busy    <= next_state inside {LOAD_W, ACT, FLUSH};
      done    <= (next_state == DONE);
      w_ready <= (next_state == LOAD_W);
      a_ready <= (next_state == ACT);
      wen     <= w_hs;
      if (w_hs)
        win <= w_data;
      if (state == IDLE && start)
        n_vec_q <= n_vec;
      if (next_state != state)
        w_cnt <= '0;
      else if (w_hs || state == FLUSH)
        w_cnt <= w_cnt + WC_W'(1);
      if (next_state != state)
        v_cnt <= '0;
      else if (a_hs)
        v_cnt <= v_cnt + CNT_W'(1);
    end
  end

  // Lane k waits k cycles; a missed handshake injects a zero bubble.
  for (genvar k = 0; k < ROWS; k++) begin : g_lane
    sa_skew_lane #(
      .DEPTH  (k),
      .DATA_W (DATA_W)
    ) u_lane (
      .clk     (clk),
      .reset_n (reset_n),
      .d       (a_hs ? a_data[k*DATA_W +: DATA_W] : {DATA_W{1'b0}}),
      .dv      (a_hs),
      .q       (lane_q[k*DATA_W +: DATA_W]),
      .qv      (lane_qv[k])
    );
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ain       <= '0;
      ain_valid <= '0;
    end else begin
      ain       <= lane_q;
      ain_valid <= lane_qv;
    end
  end

endmodule

// File: tb/tb_sa_feeder.sv
// Randomized bench for sa_feeder: a job-level reference model predicts every
// output each cycle, plus per-job pulse counts and an abort-by-reset case.
module tb_sa_feeder;
  import sa_share::*;

  localparam int ROWS   = DEF_ROWS;
  localparam int DATA_W = DEF_DATA_W;
  localparam int CNT_W  = DEF_CNT_W;
  localparam int RING   = 16;
  localparam int BUDGET = 2000;

  logic                   clk = 1'b0;
  logic                   reset_n = 1'b0;
  logic                   start = 1'b0;
  logic [CNT_W-1:0]       n_vec = '0;
  logic                   busy, done;
  logic                   w_valid = 1'b0;
  logic                   w_ready;
  logic [DATA_W-1:0]      w_data = '0;
  logic                   a_valid = 1'b0;
  logic                   a_ready;
  logic [ROWS*DATA_W-1:0] a_data = '0;
  logic [DATA_W-1:0]      win;
  logic                   wen;
  logic [ROWS*DATA_W-1:0] ain;
  logic [ROWS-1:0]        ain_valid;

  always #(TB_CLK_PERIOD/2) clk = ~clk;

  sa_feeder #(.ROWS(ROWS), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .n_vec     (n_vec),
    .busy      (busy),
    .done      (done),
    .w_valid   (w_valid),
    .w_ready   (w_ready),
    .w_data    (w_data),
    .a_valid   (a_valid),
    .a_ready   (a_ready),
    .a_data    (a_data),
    .win       (win),
    .wen       (wen),
    .ain       (ain),
    .ain_valid (ain_valid)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Job-level model: remaining weights, vectors and drain cycles of the current job.
  bit                m_active = 1'b0;
  bit                m_done   = 1'b0;
  int                m_w_left = 0;
  int                m_v_left = 0;
  int                m_f_left = 0;
  bit                m_wen    = 1'b0;
  logic [DATA_W-1:0] m_win    = '0;
  logic [DATA_W-1:0] ring_d [RING][ROWS];
  bit                ring_v [RING][ROWS];

  int wen_seen, done_seen, av0_seen;

  bit                     wv_pat[$];
  logic [DATA_W-1:0]      wd_pat[$];
  bit                     av_pat[$];
  logic [ROWS*DATA_W-1:0] ad_pat[$];

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp_v, cyc);
    end
  endtask

  task automatic clearModel();
    m_active = 1'b0; m_done = 1'b0;
    m_w_left = 0; m_v_left = 0; m_f_left = 0;
    m_wen = 1'b0; m_win = '0;
    for (int s = 0; s < RING; s++)
      for (int k = 0; k < ROWS; k++) begin
        ring_d[s][k] = '0;
        ring_v[s][k] = 1'b0;
      end
  endtask

  task automatic compareCycle();
    logic [ROWS*DATA_W-1:0] e_ain;
    logic [ROWS-1:0]        e_av;
    int s;
    s = cyc % RING;
    for (int k = 0; k < ROWS; k++) begin
      e_ain[k*DATA_W +: DATA_W] = ring_d[s][k];
      e_av[k] = ring_v[s][k];
      ring_d[s][k] = '0;
      ring_v[s][k] = 1'b0;
    end
    checkOutput("busy",      64'(busy),      64'(m_active));
    checkOutput("done",      64'(done),      64'(m_done));
    checkOutput("w_ready",   64'(w_ready),   64'(m_active && m_w_left > 0));
    checkOutput("a_ready",   64'(a_ready),   64'(m_active && m_w_left == 0 && m_v_left > 0));
    checkOutput("wen",       64'(wen),       64'(m_wen));
    checkOutput("win",       64'(win),       64'(m_win));
    checkOutput("ain",       64'(ain),       64'(e_ain));
    checkOutput("ain_valid", 64'(ain_valid), 64'(e_av));
  endtask

  task automatic modelStep();
    bit wr, ar, fl, whs, ahs;
    wr  = m_active && m_w_left > 0;
    ar  = m_active && m_w_left == 0 && m_v_left > 0;
    fl  = m_active && m_w_left == 0 && m_v_left == 0 && m_f_left > 0;
    whs = wr && w_valid;
    ahs = ar && a_valid;
    m_wen = whs;
    if (whs) m_win = w_data;
    if (ahs)
      for (int k = 0; k < ROWS; k++) begin
        ring_d[(cyc + 1 + k) % RING][k] = a_data[k*DATA_W +: DATA_W];
        ring_v[(cyc + 1 + k) % RING][k] = 1'b1;
      end
    if (m_done) m_done = 1'b0;
    else if (!m_active) begin
      if (start) begin
        m_active = 1'b1;
        m_w_left = ROWS;
        m_v_left = int'(n_vec);
        m_f_left = (n_vec != '0) ? ROWS : 0;
      end
    end else begin
      if (whs) m_w_left--;
      if (ahs) m_v_left--;
      if (fl)  m_f_left--;
      if (m_w_left == 0 && m_v_left == 0 && m_f_left == 0) begin
        m_active = 1'b0;
        m_done   = 1'b1;
      end
    end
  endtask

  // One clock cycle: check what the DUT shows now, drive the next inputs, advance the model.
  task automatic applyStimulus(input bit st, input logic [CNT_W-1:0] nv,
                               input bit wv, input logic [DATA_W-1:0] wd,
                               input bit av, input logic [ROWS*DATA_W-1:0] ad);
    compareCycle();
    if (wen) wen_seen++;
    if (done) done_seen++;
    if (ain_valid[0]) av0_seen++;
    start = st; n_vec = nv;
    w_valid = wv; w_data = wd;
    a_valid = av; a_data = ad;
    modelStep();
    cyc++;
    @(negedge clk);
  endtask

  task automatic runJob(input logic [CNT_W-1:0] n, input int w_pct, input int a_pct,
                        input bit poke_start, input string name);
    int budget;
    bit wr, ar, wv, av, st;
    logic [DATA_W-1:0]      wd;
    logic [ROWS*DATA_W-1:0] ad;
    wen_seen = 0; done_seen = 0; av0_seen = 0;
    applyStimulus(1'b1, n, 1'b0, '0, 1'b0, '0);
    budget = 0;
    while ((m_active || m_done) && budget < BUDGET) begin
      wr = m_active && m_w_left > 0;
      ar = m_active && m_w_left == 0 && m_v_left > 0;
      if (wr && wv_pat.size() > 0) wv = wv_pat.pop_front();
      else wv = (int'($urandom_range(99)) < w_pct);
      wd = DATA_W'($urandom);
      if (wr && wv && wd_pat.size() > 0) wd = wd_pat.pop_front();
      if (ar && av_pat.size() > 0) av = av_pat.pop_front();
      else av = (int'($urandom_range(99)) < a_pct);
      ad = (ROWS*DATA_W)'($urandom);
      if (ar && av && ad_pat.size() > 0) ad = ad_pat.pop_front();
      st = poke_start && ($urandom_range(3) == 0);
      applyStimulus(st, CNT_W'($urandom), wv, wd, av, ad);
      budget++;
    end
    repeat (ROWS + 2) applyStimulus(1'b0, '0, 1'($urandom), '0, 1'($urandom), '0);
    checkOutput({name, "_finished"},   64'(budget < BUDGET), 64'(1));
    checkOutput({name, "_wen_count"},  64'(wen_seen),  64'(ROWS));
    checkOutput({name, "_done_count"}, 64'(done_seen), 64'(1));
    checkOutput({name, "_ain0_count"}, 64'(av0_seen),  64'(n));
  endtask

  task automatic doReset();
    reset_n = 1'b0;
    start = 1'b0; w_valid = 1'b0; a_valid = 1'b0;
    #1;
    checkOutput("rst_busy",      64'(busy),      64'(0));
    checkOutput("rst_done",      64'(done),      64'(0));
    checkOutput("rst_w_ready",   64'(w_ready),   64'(0));
    checkOutput("rst_a_ready",   64'(a_ready),   64'(0));
    checkOutput("rst_wen",       64'(wen),       64'(0));
    checkOutput("rst_win",       64'(win),       64'(0));
    checkOutput("rst_ain",       64'(ain),       64'(0));
    checkOutput("rst_ain_valid", 64'(ain_valid), 64'(0));
    clearModel();
    @(posedge clk);
    @(negedge clk);
    cyc++;
    reset_n = 1'b1;
  endtask

  // Start a job, let it reach the streaming phase, then pull reset under it.
  task automatic runAbort();
    int act_cycles, budget;
    done_seen = 0;
    applyStimulus(1'b1, CNT_W'(5), 1'b0, '0, 1'b0, '0);
    act_cycles = 0; budget = 0;
    while (act_cycles < 2 && budget < 100) begin
      if (m_active && m_w_left == 0 && m_v_left > 0) act_cycles++;
      applyStimulus(1'b0, '0, 1'b1, DATA_W'($urandom), 1'b1, (ROWS*DATA_W)'($urandom));
      budget++;
    end
    checkOutput("abort_reached_act", 64'(act_cycles), 64'(2));
    doReset();
    repeat (ROWS + 2) applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, '0);
    checkOutput("abort_no_done", 64'(done_seen), 64'(0));
  endtask

  initial begin
    clearModel();
    repeat (2) @(negedge clk);
    compareCycle();
    reset_n = 1'b1;
    @(negedge clk);
    cyc++;

    wd_pat = '{8'd4, 8'd3, 8'd2, 8'd1};
    ad_pat = '{32'h06070809};
    runJob(CNT_W'(1), 100, 100, 1'b0, "s1_basic");

    wv_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    runJob(CNT_W'(2), 100, 70, 1'b0, "s2_wstall");

    av_pat = '{1'b1, 1'b0, 1'b1, 1'b1};
    runJob(CNT_W'(3), 100, 100, 1'b0, "s3_bubble");

    runJob(CNT_W'(0), 60, 100, 1'b0, "s4_zero");

    runJob(CNT_W'(6), 70, 60, 1'b1, "s5_restart");

    runAbort();
    wd_pat = '{8'd4, 8'd3, 8'd2, 8'd1};
    ad_pat = '{32'h06070809};
    runJob(CNT_W'(1), 100, 100, 1'b0, "s6_after_rst");

    for (int j = 0; j < 8; j++)
      runJob(CNT_W'($urandom_range(12, 1)), int'($urandom_range(100, 30)),
             int'($urandom_range(100, 30)), 1'($urandom_range(1)), "rand");

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sa_feeder.md
Name: sa_feeder

Overview:
- Drives the input side of a 1-D systolic PE chain: shifts one weight per PE into the chain over the win/wen path, then streams activation vectors with a diagonal skew onto the per-PE ain lanes.
- Sits between the weight/activation buffers (valid/ready sources) and the PE row.
- Performs in hardware the load-then-stream sequence that benches currently drive by hand.

Parameters:
- ROWS, 4, number of PEs in the chain (one weight and one ain lane each).
- DATA_W, 8, signed weight/activation width.
- CNT_W, 16, width of the activation-vector count.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a job when idle.
- n_vec  in  CNT_W  number of activation vectors in the job; sampled on accepted start.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse at job end.
- w_valid  in  1  weight source valid.
- w_ready  out  1  high only in LOAD_W.
- w_data  in  DATA_W  weight; order is the weight for PE[ROWS-1] first, PE[0] last.
- a_valid  in  1  activation source valid.
- a_ready  out  1  high only in ACT.
- a_data  in  ROWS*DATA_W  activation vector; lane k = bits [k*DATA_W +: DATA_W].
- win  out  DATA_W  to PE[0] weight input.
- wen  out  1  weight shift enable to all PEs.
- ain  out  ROWS*DATA_W  skewed activations; lane k drives PE[k].
- ain_valid  out  ROWS  per-lane valid.

Behaviour:
- Reset: all outputs 0, FSM = IDLE, weight and vector counters 0, skew registers and valids cleared.
- Reset mid-job: the job aborts without a done pulse, and the PE chain contents are undefined.
- All outputs are registered.
- FSM states: IDLE, LOAD_W, ACT, FLUSH, DONE.
- IDLE:
  - busy = 0.
  - start captures n_vec, sets busy, and moves to LOAD_W.
- LOAD_W:
  - w_ready = 1.
  - Each handshake (w_valid & w_ready) in cycle t gives win = w_data and wen = 1 in cycle t+1.
  - Cycles without a handshake give wen = 0 and hold win, so the chain holds.
  - After the ROWS-th handshake: go to ACT if n_vec != 0, else go to DONE.
  - wen is 0 in every state except the cycle after a LOAD_W handshake.
- ACT:
  - a_ready = 1.
  - A handshake in cycle t gives ain lane k = a_data lane k with ain_valid[k] = 1 in cycle t+1+k.
  - A missing handshake inserts a bubble: that slot's lanes show valid 0 and data 0 at the same skewed times.
  - After the n_vec-th handshake, go to FLUSH.
- FLUSH:
  - Lasts exactly ROWS cycles, no new acceptance, while the skew pipeline drains.
  - The last ain_valid[ROWS-1] pulse occurs in the final FLUSH cycle or earlier.
- DONE:
  - done = 1 for one cycle, busy drops in the same cycle, next state IDLE.
  - The earliest new start is accepted in the IDLE cycle after DONE.
- start while busy is ignored, and n_vec is not resampled.
- Counters:
  - Weight counter is log2(ROWS)+1 bits; no wrap inside a job.
  - Vector counter is CNT_W bits and compares against the captured n_vec.
  - n_vec = 2^CNT_W-1 must complete without wrap.
- Data passes unmodified (no sign extension); win/ain are bit-exact copies.

Decomposition:
- Shared header (sa_share) holds:
  - state encodings: IDLE=0, LOAD_W=1, ACT=2, FLUSH=3, DONE=4;
  - the default DATA_W and ROWS;
  - the bench clock constants.
- One sub-module, sa_skew_lane, with parameter DEPTH and ports clk, reset_n, d, dv, q, qv.
  - It is a DEPTH-stage delay register; DEPTH=0 is a pure wire.
  - It is instantiated ROWS times with DEPTH = k, behind a common one-cycle output register.

Test Plan:
1. ROWS=4, start with n_vec=1, weights 4,3,2,1 with w_valid continuously high -> wen high 4 consecutive cycles with win = 4,3,2,1. Then the vector (9,8,7,6) accepted at cycle t gives ain[0]=9 at t+1, ain[1]=8 at t+2, ain[2]=7 at t+3, ain[3]=6 at t+4. done pulses once, then busy = 0.
2. Weight stalls (w_valid pattern 1,0,0,1,1,0,1) -> wen pattern exactly 1,0,0,1,1,0,1 delayed one cycle; win holds during gaps; exactly 4 wen pulses.
3. n_vec=3 with a_valid 1,0,1,1 -> ain_valid[0] = 1,0,1,1 starting t+1, and ain_valid[3] shows the same pattern shifted +3. The bubble lanes carry 0, and done follows exactly 4 FLUSH cycles.
4. n_vec=0 -> after 4 weight handshakes go straight to DONE; a_ready never asserts and ain_valid stays 0.
5. start pulsed during LOAD_W and during ACT -> ignored; a single done, and the captured n_vec is unchanged.
6. reset_n low for 1 cycle mid-ACT -> all outputs 0 immediately (asynchronous), no done; a following start with n_vec=1 completes the whole of scenario 1 correctly.
